pakout_chk: RTL and testbench
=============================

PAKOUT_CHK -- requirements
Module: pakout_chk

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  PSZ  `NS_PACKET_SIZE  packet width
  ASZ  `NS_ADDRESS_SIZE  address field width
  DSZ  `NS_DATA_SIZE  data field width
  RSZ  `NS_REDUN_SIZE  redundancy field width
  MIN_ADDR  1  lowest legal address
  MAX_ADDR  14  highest legal address
REQ-002 Ports (name, direction, width, meaning), one per line:
  i_clk  in  1  single clock; all logic on its rising edge
  reset  in  1  synchronous, active-low reset
  i_req  in  1  4-phase request from upstream packet sender (pakin snd channel)
  i_data  in  PSZ  packet; valid while i_req=1
  o_ack  out  1  4-phase acknowledge
  i_clr  in  1  one-cycle pulse; clears sticky error flags
  o_pkt_cnt  out  8  accepted packet count
  o_err_cnt  out  4  total error count
  o_disp0  out  4  low nibble of last accepted address
  o_disp1  out  4  o_err_cnt mirror
  o_leds  out  4  [0] range err, [1] sequence err, [2] redundancy err, [3] heartbeat

Function
REQ-003 Packet layout: address = i_data[PSZ-1 -: ASZ], data = next DSZ bits, red = i_data[RSZ-1:0]; ASZ+DSZ+RSZ = PSZ.
REQ-004 FSM states: IDLE, CHECK, ACK.
REQ-005 IDLE: o_ack=0; i_req=1 sampled -> capture i_data, go CHECK; else stay.
REQ-006 CHECK (exactly one cycle): evaluate checks on captured packet, update counters/flags, assert o_ack, go ACK.
REQ-007 ACK: o_ack=1; i_req=0 sampled -> o_ack=0 next cycle, go IDLE; else stay.
REQ-008 o_ack is registered; latency req-high-sample to o_ack=1 is 2 rising edges.
REQ-009 i_data is sampled only in IDLE on i_req=1; changes at other times are ignored.
REQ-010 Range check: error if address < MIN_ADDR or > MAX_ADDR.
REQ-011 Sequence check: error if address != expected; skipped for the first packet after reset.
REQ-012 Expected update: MIN_ADDR after range error or after MAX_ADDR; otherwise address+1.
REQ-013 Redundancy check: error if red != (address + data) mod 2^RSZ.
REQ-014 Each failed check sets its o_leds bit (sticky) and adds 1 to o_err_cnt; up to 3 per packet.
REQ-015 o_err_cnt saturates at 15.
REQ-016 o_pkt_cnt increments once per packet in CHECK; wraps 255->0.
REQ-017 o_leds[3] toggles once per accepted packet.
REQ-018 o_disp0 updates in CHECK; o_disp1 = o_err_cnt combinationally.
REQ-019 i_clr clears o_leds[2:0] only; if i_clr coincides with CHECK setting a flag, the set wins; counters are unaffected.
REQ-020 i_req=1 held through ACK yields no second capture; a new packet requires i_req=0 then 1.

Reset
REQ-021 reset=0 at a rising edge -> state IDLE, o_ack=0, counters=0, o_leds=0, o_disp0=0, first-packet flag set; applies in any state.
REQ-022 Reset mid-handshake drops o_ack next cycle; upstream must deassert i_req before its next packet is accepted.

Verification
REQ-023 Legal addresses 1..14 in sequence, correct red, wrap 14->1 -> o_pkt_cnt=15, o_err_cnt=0, o_leds[2:0]=000, o_leds[3]=1.
REQ-024 Address 0 after address 5 -> o_leds[0]=1 and o_leds[1]=1, o_err_cnt=2; next address 1 is accepted with no new error.
REQ-025 Address 3 with red field off by one -> o_leds[2]=1, o_err_cnt +1; o_disp0=3.
REQ-026 i_req held 1 for 10 cycles -> one capture, o_ack=1 from cycle 2 until 1 cycle after i_req=0; o_pkt_cnt +1.
REQ-027 20 bad-sequence packets -> o_err_cnt=15 (saturated); i_clr pulse -> o_leds[2:0]=000, o_err_cnt=15.
REQ-028 reset=0 while in ACK -> next cycle o_ack=0, all counters 0, first packet afterwards skips the sequence check.

Source files
------------

// File: rtl/pakout_chk.sv
// Receiving end of the pakin 4-phase packet link: captures each packet, checks
// address range, address sequence and redundancy, and keeps counters/flags.
`ifndef NS_PACKET_SIZE
`define NS_PACKET_SIZE 16
`endif
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 4
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module pakout_chk #(
   parameter int PSZ      = `NS_PACKET_SIZE,
   parameter int ASZ      = `NS_ADDRESS_SIZE,
   parameter int DSZ      = `NS_DATA_SIZE,
   parameter int RSZ      = `NS_REDUN_SIZE,
   parameter int MIN_ADDR = 1,
   parameter int MAX_ADDR = 14
) (
   input  logic           i_clk,
   input  logic           reset,
   input  logic           i_req,
   input  logic [PSZ-1:0] i_data,
   output logic           o_ack,
   input  logic           i_clr,
   output logic [7:0]     o_pkt_cnt,
   output logic [3:0]     o_err_cnt,
   output logic [3:0]     o_disp0,
   output logic [3:0]     o_disp1,
   output logic [3:0]     o_leds,
   output logic [1:0]     o_state_dbg
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CHECK = 2'd1;
   localparam logic [1:0] ST_ACK   = 2'd2;

   localparam logic [ASZ-1:0] MIN_A = ASZ'(MIN_ADDR);
   localparam logic [ASZ-1:0] MAX_A = ASZ'(MAX_ADDR);
   localparam int             AXW   = (ASZ > 4) ? ASZ : 4;

   logic [1:0]     state_q, state_d;
   logic [PSZ-1:0] cap_q, cap_d;
   logic           ack_q, ack_d;
   logic [7:0]     pkt_q, pkt_d;
   logic [3:0]     err_q, err_d;
   logic [3:0]     leds_q, leds_d;
   logic [3:0]     disp0_q, disp0_d;
   logic [ASZ-1:0] exp_q, exp_d;
   logic           first_q, first_d;
   logic           armed_q, armed_d;

   logic [ASZ-1:0] cap_addr;
   logic [DSZ-1:0] cap_dat;
   logic [RSZ-1:0] cap_red;
   logic [RSZ-1:0] red_calc;
   logic           range_err, seq_err, red_err;
   logic [1:0]     n_err;
   logic [4:0]     err_sum;
   logic [3:0]     err_sat;
   logic [AXW-1:0] addr_ext;
   logic [ASZ-1:0] next_exp;

   assign cap_addr  = cap_q[PSZ-1 -: ASZ];
   assign cap_dat   = cap_q[PSZ-1-ASZ -: DSZ];
   assign cap_red   = cap_q[RSZ-1:0];
   assign red_calc  = RSZ'(cap_addr) + RSZ'(cap_dat);
   assign range_err = (cap_addr < MIN_A) || (cap_addr > MAX_A);
   assign seq_err   = !first_q && (cap_addr != exp_q);
   assign red_err   = (cap_red != red_calc);
   assign n_err     = 2'(range_err) + 2'(seq_err) + 2'(red_err);
   assign err_sum   = {1'b0, err_q} + {3'b000, n_err};
   assign err_sat   = err_sum[4] ? 4'hF : err_sum[3:0];
   assign addr_ext  = AXW'(cap_addr);
   // Out-of-range addresses and the top address both restart the sequence.
   assign next_exp  = (range_err || (cap_addr == MAX_A)) ? MIN_A : cap_addr + ASZ'(1);

   always_comb begin
      state_d = state_q;
      cap_d   = cap_q;
      ack_d   = ack_q;
      pkt_d   = pkt_q;
      err_d   = err_q;
      leds_d  = {leds_q[3], i_clr ? 3'b000 : leds_q[2:0]};
      disp0_d = disp0_q;
      exp_d   = exp_q;
      first_d = first_q;
      // A capture needs i_req seen low first, so a request held across ACK or reset is not re-taken.
      armed_d = armed_q | ~i_req;
      case (state_q)
         ST_IDLE: begin
            if (i_req && armed_q) begin
               cap_d   = i_data;
               armed_d = 1'b0;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            ack_d       = 1'b1;
            pkt_d       = pkt_q + 8'd1;
            err_d       = err_sat;
            leds_d[0]   = leds_d[0] | range_err;
            leds_d[1]   = leds_d[1] | seq_err;
            leds_d[2]   = leds_d[2] | red_err;
            leds_d[3]   = ~leds_q[3];
            disp0_d     = addr_ext[3:0];
            exp_d       = next_exp;
            first_d     = 1'b0;
            state_d     = ST_ACK;
         end
         ST_ACK: begin
            if (!i_req) begin
               ack_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            ack_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cap_q   <= '0;
         ack_q   <= 1'b0;
         pkt_q   <= 8'd0;
         err_q   <= 4'd0;
         leds_q  <= 4'd0;
         disp0_q <= 4'd0;
         exp_q   <= MIN_A;
         first_q <= 1'b1;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cap_q   <= cap_d;
         ack_q   <= ack_d;
         pkt_q   <= pkt_d;
         err_q   <= err_d;
         leds_q  <= leds_d;
         disp0_q <= disp0_d;
         exp_q   <= exp_d;
         first_q <= first_d;
         armed_q <= armed_d;
      end
   end

   assign o_ack       = ack_q;
   assign o_pkt_cnt   = pkt_q;
   assign o_err_cnt   = err_q;
   assign o_disp0     = disp0_q;
   assign o_disp1     = err_q;
   assign o_leds      = leds_q;
   assign o_state_dbg = state_q;

endmodule

// File: tb/tb_pakout_chk.sv
// Directed bench for pakout_chk: a packet-level model checked every cycle,
// plus literal expectations at the end of each scenario.
module tb_pakout_chk;

   logic        i_clk = 1'b0;
   logic        reset;
   logic        i_req;
   logic [15:0] i_data;
   logic        i_clr;
   logic        o_ack;
   logic [7:0]  o_pkt_cnt;
   logic [3:0]  o_err_cnt;
   logic [3:0]  o_disp0;
   logic [3:0]  o_disp1;
   logic [3:0]  o_leds;
   logic [1:0]  o_state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] pend_q[$];

   // model state
   int         m_pkt, m_err, m_disp0, m_exp;
   bit         m_first;
   logic [3:0] m_leds;
   bit         m_valid = 1'b0;
   logic       s_reset = 1'b0, s_clr = 1'b0, s_ack = 1'b0;

   pakout_chk dut (
      .i_clk(i_clk), .reset(reset), .i_req(i_req), .i_data(i_data),
      .o_ack(o_ack), .i_clr(i_clr), .o_pkt_cnt(o_pkt_cnt),
      .o_err_cnt(o_err_cnt), .o_disp0(o_disp0), .o_disp1(o_disp1),
      .o_leds(o_leds), .o_state_dbg(o_state_dbg)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int red_of(input int a, input int d);
      return (a + d) % 16;
   endfunction

   task automatic model_reset();
      m_pkt = 0; m_err = 0; m_disp0 = 0; m_exp = 1; m_first = 1'b1;
      m_leds = 4'd0; m_valid = 1'b1;
      pend_q.delete();
   endtask

   task automatic model_apply();
      logic [15:0] p;
      int a, d, r;
      bit rng, sq, rd;
      if (pend_q.size() == 0) begin
         check("unexpected_ack", 1, 0);
         return;
      end
      p = pend_q.pop_front();
      a = int'(p[15:12]); d = int'(p[11:4]); r = int'(p[3:0]);
      rng = (a < 1) || (a > 14);
      sq  = !m_first && (a != m_exp);
      rd  = (r != red_of(a, d));
      m_err = m_err + int'(rng) + int'(sq) + int'(rd);
      if (m_err > 15) m_err = 15;
      if (rng) m_leds[0] = 1'b1;
      if (sq)  m_leds[1] = 1'b1;
      if (rd)  m_leds[2] = 1'b1;
      m_leds[3] = ~m_leds[3];
      m_pkt   = (m_pkt + 1) % 256;
      m_disp0 = a;
      m_exp   = (rng || a == 14) ? 1 : a + 1;
      m_first = 1'b0;
   endtask

   // Inputs change just after posedge, so values seen at a negedge are the
   // ones the following posedge samples.
   initial begin
      forever begin
         @(negedge i_clk);
         if (!s_reset) begin
            model_reset();
            check("ack_in_reset", int'(o_ack), 0);
         end else begin
            if (s_clr) m_leds[2:0] = 3'b000;
            if (o_ack && !s_ack) model_apply();
         end
         if (m_valid) begin
            check("pkt_cnt", int'(o_pkt_cnt), m_pkt);
            check("err_cnt", int'(o_err_cnt), m_err);
            check("disp1",   int'(o_disp1),   m_err);
            check("disp0",   int'(o_disp0),   m_disp0);
            check("leds",    int'(o_leds),    int'(m_leds));
         end
         s_reset = reset; s_clr = i_clr; s_ack = o_ack;
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic wait_ack(input logic lvl);
      int n = 0;
      while (o_ack !== lvl && n < 20) begin
         tick();
         n++;
      end
      check("ack_wait", int'(o_ack), int'(lvl));
   endtask

   task automatic raise(input int a, input int d, input int r);
      i_data = {4'(a), 8'(d), 4'(r)};
      i_req  = 1'b1;
      pend_q.push_back(i_data);
   endtask

   task automatic send(input int a, input int d, input int r);
      raise(a, d, r);
      wait_ack(1'b1);
      i_req = 1'b0;
      wait_ack(1'b0);
   endtask

   task automatic good(input int a, input int d);
      send(a, d, red_of(a, d));
   endtask

   initial begin
      reset = 1'b0; i_req = 1'b0; i_clr = 1'b0; i_data = 16'h0;
      repeat (3) tick();
      check("rst_ack",  int'(o_ack), 0);
      check("rst_pkt",  int'(o_pkt_cnt), 0);
      check("rst_err",  int'(o_err_cnt), 0);
      check("rst_leds", int'(o_leds), 0);
      check("rst_disp0", int'(o_disp0), 0);
      reset = 1'b1;
      repeat (2) tick();

      // legal sequence 1..14 then wrap to 1
      for (int a = 1; a <= 14; a++) good(a, a * 17);
      good(1, 8'hA5);
      check("seq_pkt", int'(o_pkt_cnt), 15);
      check("seq_err", int'(o_err_cnt), 0);
      check("seq_leds", int'(o_leds), 4'b1000);
      check("seq_disp0", int'(o_disp0), 1);

      // address 0 after 5: range and sequence errors, then 1 resyncs
      for (int a = 2; a <= 5; a++) good(a, 8'h33);
      good(0, 0);
      check("a0_err", int'(o_err_cnt), 2);
      check("a0_leds", int'(o_leds[1:0]), 2'b11);
      good(1, 8'h42);
      check("a1_err", int'(o_err_cnt), 2);
      check("a1_leds2", int'(o_leds[2]), 0);

      // redundancy off by one on address 3
      good(2, 8'h07);
      send(3, 8'h10, 4);
      check("red_err", int'(o_err_cnt), 3);
      check("red_led", int'(o_leds), 4'b1111);
      check("red_disp0", int'(o_disp0), 3);
      check("red_disp1", int'(o_disp1), 3);

      i_clr = 1'b1; tick(); i_clr = 1'b0; tick();
      check("clr_leds", int'(o_leds), 4'b1000);
      check("clr_err", int'(o_err_cnt), 3);

      // request held high for 10 cycles
      raise(4, 8'h81, red_of(4, 8'h81));
      for (int k = 1; k <= 10; k++) begin
         tick();
         check("hold_ack", int'(o_ack), (k >= 2) ? 1 : 0);
      end
      i_req = 1'b0;
      for (int k = 11; k <= 13; k++) begin
         tick();
         check("hold_ack_low", int'(o_ack), 0);
      end
      check("hold_pkt", int'(o_pkt_cnt), 24);

      // clear coincides with a sequence error being set
      raise(7, 8'h01, red_of(7, 8'h01));
      tick();
      i_clr = 1'b1;
      tick();
      i_clr = 1'b0;
      check("clrset_ack", int'(o_ack), 1);
      i_req = 1'b0;
      wait_ack(1'b0);
      check("clrset_leds", int'(o_leds[2:0]), 3'b010);
      check("clrset_err", int'(o_err_cnt), 4);

      // error counter saturation
      for (int k = 0; k < 20; k++) good(3, 0);
      check("sat_err", int'(o_err_cnt), 15);
      i_clr = 1'b1; tick(); i_clr = 1'b0; tick();
      check("sat_clr_leds", int'(o_leds[2:0]), 0);
      check("sat_clr_err", int'(o_err_cnt), 15);

      // reset while in ACK, request still held
      raise(6, 8'h20, red_of(6, 8'h20));
      wait_ack(1'b1);
      reset = 1'b0;
      tick();
      check("mid_rst_ack", int'(o_ack), 0);
      check("mid_rst_pkt", int'(o_pkt_cnt), 0);
      check("mid_rst_err", int'(o_err_cnt), 0);
      check("mid_rst_leds", int'(o_leds), 0);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("held_req_no_ack", int'(o_ack), 0);
      end
      i_req = 1'b0;
      tick();
      good(9, 8'h11);
      check("first_pkt", int'(o_pkt_cnt), 1);
      check("first_err", int'(o_err_cnt), 0);
      check("first_leds", int'(o_leds), 4'b1000);
      good(5, 8'h11);
      check("second_err", int'(o_err_cnt), 1);
      check("second_leds", int'(o_leds), 4'b0010);

      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
